// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the register file: buffers MEM and ALU writeback results
// in program order and retires one queued write per cycle.
module regfile_write_arbiter #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_valid,
  input  logic [ADDR_W-1:0]          mem_reg,
  input  logic [DATA_W-1:0]          mem_data,
  output logic                       mem_ready,
  input  logic                       alu_valid,
  input  logic [ADDR_W-1:0]          alu_reg,
  input  logic [DATA_W-1:0]          alu_data,
  output logic                       alu_ready,
  output logic                       WriteReg,
  output logic [ADDR_W-1:0]          DstReg,
  output logic [DATA_W-1:0]          DstData,
  output logic [(2**ADDR_W)-1:0]     Pending,
  output logic [$clog2(DEPTH+1)-1:0] Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] reg_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [CNT_W-1:0]  free;
  logic              enq_mem, enq_alu, deq;
  logic [PTR_W-1:0]  wr_alu_idx;

  // Ready looks only at the registered count, so no same-cycle dequeue credit.
  assign free      = CNT_W'(DEPTH) - count_q;
  assign mem_ready = (free >= CNT_W'(1));
  assign alu_ready = mem_valid ? (free >= CNT_W'(2)) : (free >= CNT_W'(1));

  assign enq_mem    = mem_valid & mem_ready & (mem_reg != '0);
  assign enq_alu    = alu_valid & alu_ready & (alu_reg != '0);
  assign deq        = (count_q != '0);
  assign wr_alu_idx = wr_ptr_q + PTR_W'(enq_mem);

  assign rd_ptr_d = rd_ptr_q + PTR_W'(deq);
  assign wr_ptr_d = wr_ptr_q + PTR_W'(enq_mem) + PTR_W'(enq_alu);
  assign count_d  = count_q + CNT_W'(enq_mem) + CNT_W'(enq_alu) - CNT_W'(deq);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (enq_mem) begin
        reg_q[wr_ptr_q]  <= mem_reg;
        data_q[wr_ptr_q] <= mem_data;
      end
      if (enq_alu) begin
        reg_q[wr_alu_idx]  <= alu_reg;
        data_q[wr_alu_idx] <= alu_data;
      end
    end
  end

  assign WriteReg = deq;
  assign DstReg   = deq ? reg_q[rd_ptr_q]  : '0;
  assign DstData  = deq ? data_q[rd_ptr_q] : '0;
  assign Count    = count_q;

  // An entry is live when its distance from the head is below the count.
  always_comb begin
    logic [PTR_W-1:0] off;
    Pending = '0;
    off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr_q;
      if (CNT_W'(off) < count_q) Pending[reg_q[i]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against a queue-based model.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, alu_valid;
  logic [3:0]  mem_reg, alu_reg;
  logic [15:0] mem_data, alu_data;
  logic        mem_ready, alu_ready;
  logic        WriteReg;
  logic [3:0]  DstReg;
  logic [15:0] DstData;
  logic [15:0] Pending;
  logic [2:0]  Count;

  int total = 0;
  int bad   = 0;

  logic [19:0] q[$];

  regfile_write_arbiter #(.DEPTH(4), .ADDR_W(4), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData),
    .Pending(Pending), .Count(Count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check against the model, clock, then update the model.
  task automatic cycle(input logic r, input logic mv, input logic [3:0] mr, input logic [15:0] md,
                       input logic av, input logic [3:0] ar, input logic [15:0] ad,
                       output logic macc, output logic aacc);
    int          sz;
    logic        emr, ear;
    logic [15:0] epend;
    rst = r; mem_valid = mv; mem_reg = mr; mem_data = md;
    alu_valid = av; alu_reg = ar; alu_data = ad;
    #1;
    sz    = q.size();
    emr   = (sz < 4);
    ear   = mv ? (sz <= 2) : (sz < 4);
    epend = '0;
    foreach (q[i]) epend[q[i][19:16]] = 1'b1;
    chk("mem_ready", 32'(mem_ready), 32'(emr));
    chk("alu_ready", 32'(alu_ready), 32'(ear));
    chk("WriteReg",  32'(WriteReg),  32'(sz != 0));
    chk("DstReg",    32'(DstReg),    (sz != 0) ? 32'(q[0][19:16]) : 32'd0);
    chk("DstData",   32'(DstData),   (sz != 0) ? 32'(q[0][15:0])  : 32'd0);
    chk("Pending",   32'(Pending),   32'(epend));
    chk("Count",     32'(Count),     32'(sz));
    macc = mv & emr & ~r;
    aacc = av & ear & ~r;
    @(posedge clk);
    if (r) q.delete();
    else begin
      if (sz != 0) void'(q.pop_front());
      if (macc && mr != 4'd0) q.push_back({mr, md});
      if (aacc && ar != 4'd0) q.push_back({ar, ad});
    end
    @(negedge clk);
  endtask

  initial begin
    logic        ma, aa;
    logic        mv, av;
    logic [3:0]  mr, ar;
    logic [15:0] md, ad;
    int          mi, ai;

    rst = 1'b1; mem_valid = 1'b0; alu_valid = 1'b0;
    mem_reg = '0; alu_reg = '0; mem_data = '0; alu_data = '0;
    @(posedge clk);
    @(negedge clk);

    // reset state and single ALU write
    cycle(0, 0, 0, 0, 1, 4'd3, 16'hDEAD, ma, aa);
    chk("t2_count", 32'(Count), 32'd1);
    chk("t2_dst", 32'(DstReg), 32'd3);
    chk("t2_pend", 32'(Pending), 32'h0008);
    cycle(0, 0, 0, 0, 0, 0, 0, ma, aa);
    chk("t2_idle", 32'(WriteReg), 32'd0);

    // simultaneous same-register writes: MEM first
    cycle(0, 1, 4'd5, 16'hBEEF, 1, 4'd5, 16'h1234, ma, aa);
    chk("t3_count", 32'(Count), 32'd2);
    chk("t3_first", 32'(DstData), 32'hBEEF);
    cycle(0, 0, 0, 0, 0, 0, 0, ma, aa);
    chk("t3_second", 32'(DstData), 32'h1234);
    chk("t3_pend", 32'(Pending), 32'h0020);
    cycle(0, 0, 0, 0, 0, 0, 0, ma, aa);
    chk("t3_clear", 32'(Pending), 32'd0);

    // backpressure and pointer wrap: 20 requests, even to MEM, odd to ALU
    mi = 0; ai = 0;
    for (int c = 0; c < 200 && (mi < 10 || ai < 10); c++) begin
      mv = (mi < 10); av = (ai < 10);
      mr = 4'((2*mi) % 15 + 1);   md = 16'hDEAD + 16'(2*mi);
      ar = 4'((2*ai+1) % 15 + 1); ad = 16'hBEEF + 16'(2*ai+1);
      cycle(0, mv, mr, md, av, ar, ad, ma, aa);
      if (ma) mi++;
      if (aa) ai++;
    end
    chk("t4_all_accepted", 32'(mi + ai), 32'd20);
    for (int c = 0; c < 10 && q.size() != 0; c++) cycle(0, 0, 0, 0, 0, 0, 0, ma, aa);
    chk("t4_drained", 32'(Count), 32'd0);

    // register 0 is dropped
    cycle(0, 0, 0, 0, 1, 4'd0, 16'hFFFF, ma, aa);
    chk("t5_count", 32'(Count), 32'd0);
    chk("t5_wr", 32'(WriteReg), 32'd0);

    // reset in the middle of operation
    cycle(0, 1, 4'd1, 16'h0101, 1, 4'd2, 16'h0202, ma, aa);
    cycle(0, 1, 4'd3, 16'h0303, 1, 4'd4, 16'h0404, ma, aa);
    chk("t6_three", 32'(Count), 32'd3);
    cycle(1, 1, 4'd6, 16'h0606, 0, 0, 0, ma, aa);
    chk("t6_count", 32'(Count), 32'd0);
    chk("t6_pend", 32'(Pending), 32'd0);
    chk("t6_wr", 32'(WriteReg), 32'd0);

    // randomized traffic holding requests until accepted
    mv = 0; av = 0; mr = 0; ar = 0; md = 0; ad = 0;
    for (int c = 0; c < 300; c++) begin
      if (!mv) begin
        mv = ($urandom_range(0, 2) != 0);
        mr = 4'($urandom_range(0, 15)); md = 16'($urandom);
      end
      if (!av) begin
        av = ($urandom_range(0, 2) != 0);
        ar = 4'($urandom_range(0, 15)); ad = 16'($urandom);
      end
      cycle(0, mv, mr, md, av, ar, ad, ma, aa);
      if (ma) mv = 0;
      if (aa) av = 0;
    end
    for (int c = 0; c < 10 && q.size() != 0; c++) cycle(0, 0, 0, 0, 0, 0, 0, ma, aa);
    chk("final_count", 32'(Count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
